// File: rtl/scroll_latch_regs_if.sv
// CPU scroll-latch bus: write strobe, address and data, as driven by the CPU side.
interface scroll_latch_regs_if;
    logic       nLATCH;
    logic [2:0] CA;
    logic [7:0] CD;

    modport master (
        output nLATCH,
        output CA,
        output CD
    );

    modport slave (
        input nLATCH,
        input CA,
        input CD
    );
endinterface

// File: rtl/scroll_latch_regs.sv
// Tile-layer scroll latch responder: captures CPU scroll writes into shadow registers,
// moves them to the active set at frame start, and produces scrolled tile coordinates
// from raster counters derived from the sync inputs.
module scroll_latch_regs #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HS_W        = 9,
    parameter int unsigned VS_W        = 8
) (
    input  logic                CLK_6M,
    input  logic                rst_n,
    scroll_latch_regs_if.slave  bus,
    input  logic                nHSYNC,
    input  logic                nVSYNC,
    input  logic                LAYER,
    output logic [HS_W-1:0]     HSCR0,
    output logic [HS_W-1:0]     HSCR1,
    output logic [VS_W-1:0]     VSCR0,
    output logic [VS_W-1:0]     VSCR1,
    output logic [HS_W-1:0]     XPOS,
    output logic [VS_W-1:0]     YPOS,
    output logic                PENDING
);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] latch_sync_q, latch_sync_d;
    logic [SYNC_STAGES-1:0] hs_sync_q, hs_sync_d;
    logic [SYNC_STAGES-1:0] vs_sync_q, vs_sync_d;

    // Two cycles of synchronised strobe history: a commit needs the strobe seen
    // high for two consecutive cycles, so a 1-clock glitch never writes.
    logic [1:0] latch_hist_q, latch_hist_d;
    logic       hs_prev_q, hs_prev_d;
    logic       vs_prev_q, vs_prev_d;

    // After reset the synchronisers hold fake zeros; count until real samples
    // reach the output, then arm edge detection only once a real low is seen.
    // This throws away a write whose strobe straddled the reset.
    logic [1:0] flush_q, flush_d;
    logic       armed_q, armed_d;

    logic [2:0] hold_ca_q, hold_ca_d;
    logic [7:0] hold_cd_q, hold_cd_d;

    logic [HS_W-1:0] hs_sh_q  [2];
    logic [HS_W-1:0] hs_sh_d  [2];
    logic [VS_W-1:0] vs_sh_q  [2];
    logic [VS_W-1:0] vs_sh_d  [2];
    logic [HS_W-1:0] hs_act_q [2];
    logic [HS_W-1:0] hs_act_d [2];
    logic [VS_W-1:0] vs_act_q [2];
    logic [VS_W-1:0] vs_act_d [2];
    logic            pending_q, pending_d;

    logic [8:0]      hcnt_q, hcnt_d;
    logic [8:0]      vcnt_q, vcnt_d;
    logic [HS_W-1:0] xpos_q, xpos_d;
    logic [VS_W-1:0] ypos_q, ypos_d;

    // ------------------------------------------------------------------
    // Decoded events
    // ------------------------------------------------------------------
    logic latch_s;
    logic hs_s;
    logic vs_s;
    logic flushed;
    logic latch_fall;
    logic h_fall;
    logic v_fall;
    logic commit;

    assign latch_s    = latch_sync_q[SYNC_STAGES-1];
    assign hs_s       = hs_sync_q[SYNC_STAGES-1];
    assign vs_s       = vs_sync_q[SYNC_STAGES-1];
    assign flushed    = (flush_q == 2'(SYNC_STAGES));
    assign latch_fall = armed_q & (&latch_hist_q) & ~latch_s;
    assign h_fall     = hs_prev_q & ~hs_s;
    assign v_fall     = vs_prev_q & ~vs_s;
    assign commit     = latch_fall & (hold_ca_q[1:0] != 2'd3);

    // Synchronisers, edge history and reset flush/arm tracking.
    always_comb begin
        latch_sync_d = {latch_sync_q[SYNC_STAGES-2:0], bus.nLATCH};
        hs_sync_d    = {hs_sync_q[SYNC_STAGES-2:0], nHSYNC};
        vs_sync_d    = {vs_sync_q[SYNC_STAGES-2:0], nVSYNC};
        latch_hist_d = {latch_hist_q[0], latch_s};
        hs_prev_d    = hs_s;
        vs_prev_d    = vs_s;
        flush_d      = flushed ? flush_q : flush_q + 2'd1;
        armed_d      = armed_q | (flushed & ~latch_s);
    end

    // Hold register follows the bus while the raw strobe is seen high.
    always_comb begin
        hold_ca_d = hold_ca_q;
        hold_cd_d = hold_cd_q;
        if (latch_sync_q[0]) begin
            hold_ca_d = bus.CA;
            hold_cd_d = bus.CD;
        end
    end

    // Shadow commit, frame transfer and pending flag.
    always_comb begin
        hs_sh_d   = hs_sh_q;
        vs_sh_d   = vs_sh_q;
        hs_act_d  = hs_act_q;
        vs_act_d  = vs_act_q;
        pending_d = pending_q;

        // Transfer reads the _q shadows, so a same-cycle commit is not seen.
        if (v_fall) begin
            hs_act_d  = hs_sh_q;
            vs_act_d  = vs_sh_q;
            pending_d = 1'b0;
        end

        if (commit) begin
            case (hold_ca_q[1:0])
                2'd0:    hs_sh_d[hold_ca_q[2]][7:0] = hold_cd_q;
                2'd1:    hs_sh_d[hold_ca_q[2]][8]   = hold_cd_q[0];
                2'd2:    vs_sh_d[hold_ca_q[2]]      = VS_W'(hold_cd_q);
                default: ;
            endcase
            pending_d = 1'b1;
        end
    end

    // Raster counters and registered scrolled coordinates.
    always_comb begin
        hcnt_d = h_fall ? 9'd0 : hcnt_q + 9'd1;

        vcnt_d = vcnt_q;
        if (v_fall) begin
            vcnt_d = 9'd0;
        end else if (h_fall) begin
            vcnt_d = vcnt_q + 9'd1;
        end

        xpos_d = HS_W'(hcnt_q) + hs_act_q[LAYER];
        ypos_d = VS_W'(vcnt_q) + vs_act_q[LAYER];
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge CLK_6M) begin
        if (!rst_n) begin
            latch_sync_q <= '0;
            hs_sync_q    <= '0;
            vs_sync_q    <= '0;
            latch_hist_q <= '0;
            hs_prev_q    <= 1'b0;
            vs_prev_q    <= 1'b0;
            flush_q      <= '0;
            armed_q      <= 1'b0;
            hold_ca_q    <= '0;
            hold_cd_q    <= '0;
            hs_sh_q      <= '{default: '0};
            vs_sh_q      <= '{default: '0};
            hs_act_q     <= '{default: '0};
            vs_act_q     <= '{default: '0};
            pending_q    <= 1'b0;
            hcnt_q       <= '0;
            vcnt_q       <= '0;
            xpos_q       <= '0;
            ypos_q       <= '0;
        end else begin
            latch_sync_q <= latch_sync_d;
            hs_sync_q    <= hs_sync_d;
            vs_sync_q    <= vs_sync_d;
            latch_hist_q <= latch_hist_d;
            hs_prev_q    <= hs_prev_d;
            vs_prev_q    <= vs_prev_d;
            flush_q      <= flush_d;
            armed_q      <= armed_d;
            hold_ca_q    <= hold_ca_d;
            hold_cd_q    <= hold_cd_d;
            hs_sh_q      <= hs_sh_d;
            vs_sh_q      <= vs_sh_d;
            hs_act_q     <= hs_act_d;
            vs_act_q     <= vs_act_d;
            pending_q    <= pending_d;
            hcnt_q       <= hcnt_d;
            vcnt_q       <= vcnt_d;
            xpos_q       <= xpos_d;
            ypos_q       <= ypos_d;
        end
    end

    assign HSCR0   = hs_act_q[0];
    assign HSCR1   = hs_act_q[1];
    assign VSCR0   = vs_act_q[0];
    assign VSCR1   = vs_act_q[1];
    assign XPOS    = xpos_q;
    assign YPOS    = ypos_q;
    assign PENDING = pending_q;

endmodule
